// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared constants for the program-counter fetch stage: instruction size,
// default memory size, return-stack depth, run/halt/fault state encoding and
// the next-PC source selector.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    localparam int INSTR_BYTES       = 3;
    localparam int MEM_BYTES_DEFAULT = 128;
    localparam int PC_W              = 24;
    localparam int RAS_DEPTH         = 4;

    // Core state machine encoding.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Source of the next PC.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_HOLD,
        SEL_RAS
    } pc_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// -----------------------------------------------------------------------------
// pc_return_stack
// Four-entry LIFO of return addresses. A push onto a full stack overwrites the
// oldest entry (circular buffer). Only used when PC_RAS_EN is defined.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset; empties the stack
//   push_i   in   push data_i
//   pop_i    in   pop the top entry (ignored when empty)
//   data_i   in   return address to push
//   top_o    out  current top entry (value a pop returns)
//   empty_o  out  stack holds no entries
// -----------------------------------------------------------------------------
module pc_return_stack
    import pc_fetch_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o
);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [1:0]      ptr_q;   // next slot to write; ptr_q-1 is the top
    logic [2:0]      cnt_q;   // number of valid entries, 0..RAS_DEPTH

    assign top_o   = mem_q[ptr_q - 2'd1];
    assign empty_o = (cnt_q == 3'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 2'd0;
            cnt_q <= 3'd0;
        end else if (push_i) begin
            ptr_q <= ptr_q + 2'd1;
            if (cnt_q != 3'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - 2'd1;
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by cnt_q alone,
    // so clearing the entries would only cost reset wiring.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter stage in front of the instruction memory. Selects the next
// PC (sequential, relative branch, absolute jump, hold, return), detects
// out-of-range targets (sticky FAULT), handles HALT/Resume and counts retired
// instructions with saturation.
// Optional feature macro: PC_RAS_EN adds a 4-entry return address stack for
// Call/Ret. Without it, Call acts as Jump and Ret is ignored.
// Ports:
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous active-low reset
//   Stall         in   hold PC, no retire, ignore all other requests
//   BranchTaken   in   take relative branch
//   BranchOffset  in   signed offset in instructions, relative to PC+3
//   Jump          in   take absolute jump
//   JumpIndex     in   absolute target as an instruction index
//   Halt          in   decoded instruction is HALT
//   Resume        in   leave HALT
//   Call / Ret    in   subroutine call / return
//   PCAddress     out  current PC byte address
//   PCPlus3       out  PCAddress + 3 (link value)
//   Halted        out  state is HALT
//   Fault         out  state is FAULT
//   RetiredCount  out  retired-instruction count (saturating)
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int RESET_PC  = 0,
    parameter int CNT_W     = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [23:0]      BranchOffset,
    input  logic             Jump,
    input  logic [23:0]      JumpIndex,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             Call,
    input  logic             Ret,
    output logic [23:0]      PCAddress,
    output logic [23:0]      PCPlus3,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] RetiredCount
);

    localparam logic signed [25:0] LAST_PC = 26'(MEM_BYTES - INSTR_BYTES);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               retire;
    pc_sel_e            sel;

    // All target arithmetic is 26-bit signed so negative results and results
    // beyond the 24-bit PC range are both visible to the range check.
    logic signed [25:0] pc_plus3_s, br_tgt, jmp_tgt, tgt;

    logic               ras_push, ras_pop, ras_empty;
    logic [PC_W-1:0]    ras_top;

    assign pc_plus3_s = $signed({2'b00, pc_q}) + 26'sd3;
    assign br_tgt     = pc_plus3_s + $signed({{2{BranchOffset[23]}}, BranchOffset}) * 26'sd3;
    assign jmp_tgt    = $signed({2'b00, JumpIndex}) * 26'sd3;

    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves one unassigned, which would infer a latch.
        sel      = SEL_HOLD;
        state_d  = state_q;
        pc_d     = pc_q;
        retire   = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        tgt      = pc_plus3_s;

        case (state_q)
            ST_RUN: begin
                if (Stall) begin
                    sel = SEL_HOLD;
                end else if (Halt) begin
                    // HALT itself retires; the PC stays on the HALT instruction.
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end
`ifdef PC_RAS_EN
                else if (Call) begin
                    sel      = SEL_JUMP;
                    ras_push = 1'b1;
                end else if (Ret) begin
                    if (ras_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        sel     = SEL_RAS;
                        ras_pop = 1'b1;
                    end
                end else if (Jump) begin
                    sel = SEL_JUMP;
                end
`else
                else if (Jump || Call) begin
                    sel = SEL_JUMP;
                end
`endif
                else if (BranchTaken) begin
                    sel = SEL_BRANCH;
                end else begin
                    sel = SEL_SEQ;
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    sel = SEL_SEQ;
                end
            end
            default: ;  // FAULT is sticky until reset
        endcase

        case (sel)
            SEL_SEQ:    tgt = pc_plus3_s;
            SEL_BRANCH: tgt = br_tgt;
            SEL_JUMP:   tgt = jmp_tgt;
            SEL_RAS:    tgt = {2'b00, ras_top};
            default:    tgt = {2'b00, pc_q};
        endcase

        if (sel != SEL_HOLD) begin
            if (tgt < 0 || tgt > LAST_PC) begin
                // Faulting instruction keeps its address and does not retire.
                state_d  = ST_FAULT;
                ras_push = 1'b0;
                ras_pop  = 1'b0;
            end else begin
                pc_d    = tgt[PC_W-1:0];
                state_d = ST_RUN;
                // Leaving HALT via Resume moves the PC but is not a retire.
                retire  = (state_q == ST_RUN);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= PC_W'(RESET_PC);
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            if (retire && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef PC_RAS_EN
    pc_return_stack u_ras (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_plus3_s[PC_W-1:0]),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );
`else
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_empty, Ret};
`endif

    assign PCAddress    = pc_q;
    assign PCPlus3      = pc_q + 24'd3;
    assign Halted       = (state_q == ST_HALT);
    assign Fault        = (state_q == ST_FAULT);
    assign RetiredCount = cnt_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter stage directly upstream of the 128-byte instruction memory. It holds the architectural PC and drives PCAddress, which is the byte address of a 3-byte instruction. It selects the next PC each cycle: sequential, relative branch, absolute jump, hold on stall, halt, or fault. It also keeps a retired-instruction counter and a run/halt/fault state machine for the single-cycle core.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes; the last legal PC is MEM_BYTES-3.
INSTR_BYTES, 3, bytes per instruction; fixed PC increment.
RESET_PC, 0, PC value loaded on reset; must be a multiple of INSTR_BYTES.
CNT_W, 32, width of the retired-instruction counter.

Ports:
Clock  in  1  rising-edge clock.
Reset  in  1  asynchronous, active-low reset.
Stall  in  1  hold the PC this cycle; no retire.
BranchTaken  in  1  take the relative branch.
BranchOffset  in  24  signed offset, in instructions, relative to PC+3.
Jump  in  1  take the absolute jump.
JumpIndex  in  24  unsigned absolute target, as an instruction index.
Halt  in  1  the decoded instruction is HALT.
Resume  in  1  single-cycle pulse; leave HALT.
Call  in  1  call (see optional feature).
Ret  in  1  return (see optional feature).
PCAddress  out  24  current PC, to the instruction memory.
PCPlus3  out  24  PCAddress+3, used as the link value.
Halted  out  1  state is HALT.
Fault  out  1  state is FAULT.
RetiredCount  out  CNT_W  number of instructions retired.

Behaviour:
- Reset (Reset=0, asynchronous): PCAddress=RESET_PC, state=RUN, Halted=0, Fault=0, RetiredCount=0. PCPlus3 is always PCAddress+3, combinational.
- States:
  - RUN: the PC updates on every rising edge unless a hold condition applies.
  - HALT: PC holds. Resume=1 moves to RUN with PCAddress=PCPlus3, the instruction after HALT. No retire on that transition.
  - FAULT: sticky. Only Reset clears it. PC holds.
- Next-PC selection in RUN. Priority is highest first:
  1. Stall=1: hold PC; no retire; all other requests are ignored this cycle.
  2. Halt=1: go to HALT; PC holds; this edge counts as one retire.
  3. Jump=1: target = JumpIndex*3.
  4. BranchTaken=1: target = PCPlus3 + BranchOffset*3.
  5. Otherwise: target = PCPlus3.
- Arithmetic:
  - Products and sums are computed in 26-bit signed.
  - Any target that is negative or greater than MEM_BYTES-3 sends the state to FAULT. In that case PCAddress keeps the faulting instruction's address and there is no retire.
  - Sequential wrap past the end of memory is also a fault; there is no silent wrap.
- Retire: RetiredCount increments by 1 on every RUN edge that updates the PC or enters HALT. It saturates at all-ones.
- Simultaneous Jump and BranchTaken: Jump wins.
- Resume while in RUN or FAULT is ignored.
- Reset during any state returns to the reset values on the same instant, asynchronously.
- Latency: a request sampled at edge N is visible on PCAddress after edge N. The instruction memory is combinational, so the instruction at the new PC is valid in the same cycle.

Optional Feature:
PC_RAS_EN.
- Defined: adds a 4-entry return address stack.
  - Call=1 (priority between Halt and Jump) pushes PCPlus3 and jumps to JumpIndex*3.
  - Ret=1 (same priority level; Call wins if both are set) pops, and the popped value becomes the target.
  - Push when full overwrites the oldest entry.
  - Pop when empty goes to FAULT.
  - Stall blocks both push and pop.
  - Reset empties the stack.
- Undefined: Call behaves exactly like Jump, and Ret is ignored. The ports remain in both builds.

Decomposition:
- Shared package holds:
  - localparams for INSTR_BYTES and the default MEM_BYTES;
  - the state encoding (RUN=2'd0, HALT=2'd1, FAULT=2'd2);
  - the next-PC select encoding (SEQ, BRANCH, JUMP, HOLD, RAS).
- One sub-module, pc_return_stack (the 4-entry LIFO), instantiated only under PC_RAS_EN.

Test Plan:
- Release reset, 4 free-running edges -> PCAddress 0,3,6,9,12; RetiredCount=4.
- At PC=9, BranchTaken=1, BranchOffset=-2 -> PC=6. Next, BranchOffset=+40 -> target 129 > 125, so Fault=1, PC stays at 6, count unchanged.
- At PC=15, Jump=1, JumpIndex=41 -> PC=123. Then Jump and BranchTaken both asserted, JumpIndex=2 -> PC=6 (Jump wins).
- At PC=21: Halt=1 -> Halted=1, PC=21 held for 5 cycles. Resume pulse -> PC=24, Halted=0. Resume while running -> no effect.
- At PC=30: Stall=1 together with Jump=1 for 3 cycles -> PC held at 30, count held. Then Reset asserted asynchronously mid-cycle -> PC=0, Fault=0, count=0 immediately.
- PC_RAS_EN: at PC=6, Call with JumpIndex=10 -> PC=30. Ret -> PC=9. Ret on the empty stack -> Fault=1.
